// File: rtl/axis_fifo.sv
// First-word-fall-through valid/ready FIFO of 2**ADDR_WIDTH entries with registered handshakes.
// Define AXIS_FIFO_FORMAL_EN to embed the bookkeeping assertions.
module axis_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  output logic [ADDR_WIDTH:0]   size,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  ivalid,
  output logic                  iready,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  ovalid,
  input  logic                  oready
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH-1:0] rptr_inc;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH:0]   size_next;
  logic [DATA_WIDTH-1:0] odata_next;

  assign push     = ivalid && iready;
  assign pop      = ovalid && oready;
  assign rptr_inc = rptr + ADDR_WIDTH'(1);

  always_comb begin
    size_next = size;
    if (push && !pop)
      size_next = size + ONE;
    else if (pop && !push)
      size_next = size - ONE;
  end

  // odata mirrors mem[rptr]; after a pop the next head is either already stored
  // or, when only one word was held, the word being pushed in the same cycle.
  always_comb begin
    odata_next = odata;
    if (pop)
      odata_next = (size == ONE) ? idata : mem[rptr_inc];
    else if (push && (size == '0))
      odata_next = idata;
  end

  always_ff @(posedge clock) begin
    if (resetn && push)
      mem[wptr] <= idata;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      size   <= '0;
      iready <= 1'b0;
      ovalid <= 1'b0;
      odata  <= '0;
      wptr   <= '0;
      rptr   <= '0;
    end else begin
      size   <= size_next;
      iready <= (size_next != FULL);
      ovalid <= (size_next != '0);
      odata  <= odata_next;
      if (push)
        wptr <= wptr + ADDR_WIDTH'(1);
      if (pop)
        rptr <= rptr_inc;
    end
  end

`ifdef AXIS_FIFO_FORMAL_EN
  logic                  past_resetn;
  logic [ADDR_WIDTH:0]   past_size_next;
  logic                  past_hold;
  logic [DATA_WIDTH-1:0] past_odata;

  always_ff @(posedge clock) begin
    past_resetn    <= resetn;
    past_size_next <= size_next;
    past_hold      <= ovalid && !oready;
    past_odata     <= odata;
  end

  always_comb begin
    if (resetn && past_resetn) begin
      assert (size == past_size_next);
      assert (size <= FULL);
      assert (ovalid == (size != '0));
      assert (iready == (size != FULL));
      assert (ADDR_WIDTH'(wptr - rptr) == size[ADDR_WIDTH-1:0]);
      if (past_hold)
        assert (ovalid && (odata == past_odata));
    end
  end
`endif

endmodule

// File: tb/tb_axis_fifo.sv
// Self-checking bench for axis_fifo: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_axis_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic          clock = 1'b0;
  logic          resetn;
  logic [AW:0]   size;
  logic [DW-1:0] idata;
  logic          ivalid;
  logic          iready;
  logic [DW-1:0] odata;
  logic          ovalid;
  logic          oready;

  int unsigned nchk = 0;
  int unsigned nerr = 0;

  axis_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .resetn(resetn),
    .size  (size),
    .idata (idata),
    .ivalid(ivalid),
    .iready(iready),
    .odata (odata),
    .ovalid(ovalid),
    .oready(oready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue; outputs are functions of its length and head.
  logic [DW-1:0] q[$];
  logic          m_iready  = 1'b0;
  logic          m_ovalid  = 1'b0;
  logic [DW-1:0] m_odata   = '0;
  logic          m_started = 1'b0;
  logic          m_rst     = 1'b0;

  always @(posedge clock) begin
    logic do_push, do_pop;
    do_push = ivalid && m_iready;
    do_pop  = m_ovalid && oready;
    if (!resetn) begin
      q.delete();
      m_started = 1'b1;
      m_rst     = 1'b1;
      m_odata   = '0;
      m_iready  = 1'b0;
      m_ovalid  = 1'b0;
    end else begin
      m_rst = 1'b0;
      if (do_pop)
        void'(q.pop_front());
      if (do_push)
        q.push_back(idata);
      m_iready = (q.size() != DEPTH);
      m_ovalid = (q.size() != 0);
      if (q.size() != 0)
        m_odata = q[0];
    end
  end

  always @(negedge clock) begin
    if (m_started) begin
      check("size",   32'(size),   32'(q.size()));
      check("iready", 32'(iready), 32'(m_iready));
      check("ovalid", 32'(ovalid), 32'(m_ovalid));
      if (m_ovalid || m_rst)
        check("odata", 32'(odata), 32'(m_odata));
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  logic [DW-1:0] got[$];
  int unsigned   k;
  logic          acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; ivalid = 1'b0; oready = 1'b0; idata = '0;
    step; step;
    check("rst_size",   32'(size),   0);
    check("rst_ovalid", 32'(ovalid), 0);
    check("rst_iready", 32'(iready), 0);
    check("rst_odata",  32'(odata),  0);
    resetn = 1'b1;
    step;
    check("rel_iready", 32'(iready), 1);
    check("rel_size",   32'(size),   0);
    check("rel_ovalid", 32'(ovalid), 0);

    // single push into empty FIFO
    ivalid = 1'b1; idata = 8'h11;
    step;
    ivalid = 1'b0;
    check("p1_ovalid", 32'(ovalid), 1);
    check("p1_odata",  32'(odata),  32'h11);
    check("p1_size",   32'(size),   1);
    oready = 1'b1;
    step;
    oready = 1'b0;
    check("p1_drain", 32'(size), 0);

    // fill to capacity, extra word refused
    for (int i = 1; i <= 4; i++) begin
      ivalid = 1'b1; idata = DW'(i);
      step;
    end
    check("full_size",   32'(size),   4);
    check("full_iready", 32'(iready), 0);
    idata = 8'h05;
    step;
    check("full_hold_size", 32'(size),  4);
    check("full_head",      32'(odata), 32'h01);

    // pop while full: push only enabled the following cycle
    got.delete();
    oready = 1'b1;
    got.push_back(odata);
    step;
    check("fpop_size",   32'(size),   3);
    check("fpop_iready", 32'(iready), 1);
    got.push_back(odata);
    step;
    ivalid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (ovalid) got.push_back(odata);
      step;
    end
    oready = 1'b0;
    check("fpop_count", 32'(got.size()), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      check("fpop_order", 32'(got[i]), 32'(i + 1));

    // streaming 20 words across pointer wrap
    got.delete();
    k = 0;
    ivalid = 1'b1; oready = 1'b1; idata = '0;
    for (int c = 0; c < 60; c++) begin
      if (ovalid) got.push_back(odata);
      acc = ivalid && iready;
      step;
      if (acc) k++;
      if (k == 10) check("stream_size", 32'(size), 1);
      if (k >= 20) ivalid = 1'b0;
      idata = DW'(k);
      if (k >= 20 && !ovalid) break;
    end
    oready = 1'b0; ivalid = 1'b0;
    check("stream_count", 32'(got.size()), 20);
    for (int i = 0; i < 20 && i < got.size(); i++)
      check("stream_order", 32'(got[i]), 32'(i));

    // reset in the middle of a push and pop with 3 words held
    for (int i = 0; i < 3; i++) begin
      ivalid = 1'b1; idata = DW'(8'hA0 + i);
      step;
    end
    check("mid_size", 32'(size), 3);
    ivalid = 1'b1; oready = 1'b1; idata = 8'hA3; resetn = 1'b0;
    step;
    check("mrst_size",   32'(size),   0);
    check("mrst_ovalid", 32'(ovalid), 0);
    resetn = 1'b1; ivalid = 1'b0; oready = 1'b0;
    step;
    ivalid = 1'b1; idata = 8'h77;
    step;
    ivalid = 1'b0;
    check("mrst_odata", 32'(odata), 32'h77);
    check("mrst_cnt",   32'(size),  1);
    oready = 1'b1;
    step;
    oready = 1'b0;

    // randomized traffic with varying pressure and rare resets
    for (int blk = 0; blk < 6; blk++) begin
      int unsigned pin, pout;
      pin  = $urandom_range(1, 9);
      pout = $urandom_range(1, 9);
      for (int c = 0; c < 500; c++) begin
        resetn = ($urandom_range(0, 199) != 0);
        ivalid = ($urandom_range(0, 9) < pin);
        oready = ($urandom_range(0, 9) < pout);
        idata  = DW'($urandom);
        step;
      end
    end
    resetn = 1'b1; ivalid = 1'b0; oready = 1'b0;
    step;

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule
